// File: rtl/rv32i_apb_pkg.sv
// Shared types, defaults and address-decode helper for the RV32I APB master.
package rv32i_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

  localparam logic [31:0] APB_BASE_ADDR        = 32'h1000_0000;
  localparam int unsigned APB_SLV_SIZE_LOG2    = 12;
  localparam logic [31:0] APB_TIMEOUT_ERR_DATA = 32'hDEAD_BEEF;

  // Returns {hit, idx[2:0]}; idx is only meaningful when hit is set.
  function automatic logic [3:0] apb_decode(
    input logic [31:0] addr,
    input logic [31:0] base     = APB_BASE_ADDR,
    input int unsigned sizeLog2 = APB_SLV_SIZE_LOG2,
    input int unsigned numSlv   = 4
  );
    logic [31:0] slot;
    logic        hit;
    slot = (addr - base) >> sizeLog2;
    hit  = (addr >= base) && (slot < numSlv);
    return {hit, slot[2:0]};
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral-window decode: hit flag, slave index and one-hot select.
module apb_addr_decoder
  import rv32i_apb_pkg::*;
#(
  parameter int unsigned NUM_SLV       = 4,
  parameter logic [31:0] BASE_ADDR     = APB_BASE_ADDR,
  parameter int unsigned SLV_SIZE_LOG2 = APB_SLV_SIZE_LOG2
) (
  input  logic [31:0]        iAddr,
  output logic               oHit,
  output logic [2:0]         oIdx,
  output logic [NUM_SLV-1:0] oSel
);

  always_comb begin
    {oHit, oIdx} = apb_decode(iAddr, BASE_ADDR, SLV_SIZE_LOG2, NUM_SLV);
    oSel = '0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (oHit && (oIdx == 3'(k))) oSel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_apb_master.sv
// Core data-port to APB4 bridge: one transfer at a time, core stalled until oDone.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module rv32i_apb_master
  import rv32i_apb_pkg::*;
#(
  parameter int unsigned NUM_SLV       = 4,
  parameter logic [31:0] BASE_ADDR     = APB_BASE_ADDR,
  parameter int unsigned SLV_SIZE_LOG2 = APB_SLV_SIZE_LOG2,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iReq,
  input  logic                   iWe,
  input  logic [31:0]            iAddr,
  input  logic [31:0]            iWData,
  input  logic [3:0]             iBe,
  output logic                   oStall,
  output logic                   oDone,
  output logic [31:0]            oRData,
  output logic                   oErr,
  output logic [31:0]            oPAddr,
  output logic                   oPWrite,
  output logic [NUM_SLV-1:0]     oPSel,
  output logic                   oPEnable,
  output logic [31:0]            oPWData,
  output logic [3:0]             oPStrb,
  input  logic [32*NUM_SLV-1:0]  iPRData,
  input  logic [NUM_SLV-1:0]     iPReady,
  input  logic [NUM_SLV-1:0]     iPSlvErr
);

  apb_state_e          state;
  logic [2:0]          idxQ;
  logic                decHit;
  logic [2:0]          decIdx;
  logic [NUM_SLV-1:0]  decSel;
  logic                selReady;
  logic                selErr;
  logic [31:0]         selData;

  apb_addr_decoder #(
    .NUM_SLV      (NUM_SLV),
    .BASE_ADDR    (BASE_ADDR),
    .SLV_SIZE_LOG2(SLV_SIZE_LOG2)
  ) uDecoder (
    .iAddr(iAddr),
    .oHit (decHit),
    .oIdx (decIdx),
    .oSel (decSel)
  );

  // Only the latched slave's response is observed; others are ignored.
  always_comb begin
    selReady = 1'b0;
    selErr   = 1'b0;
    selData  = '0;
    for (int unsigned k = 0; k < NUM_SLV; k++) begin
      if (idxQ == 3'(k)) begin
        selReady = iPReady[k];
        selErr   = iPSlvErr[k];
        selData  = iPRData[32*k +: 32];
      end
    end
  end

  // Stall is combinational in IDLE so the core never advances on the request cycle.
  assign oStall = iRst & ((state == SETUP) | (state == ACCESS) | ((state == IDLE) & iReq));
  assign oDone  = (state == DONE);

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] toCnt;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state    <= IDLE;
      idxQ     <= '0;
      oPSel    <= '0;
      oPEnable <= 1'b0;
      oErr     <= 1'b0;
      oRData   <= '0;
      oPAddr   <= '0;
      oPWData  <= '0;
      oPStrb   <= '0;
      oPWrite  <= 1'b0;
`ifdef APB_TIMEOUT_EN
      toCnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            oErr   <= ~decHit;
            oRData <= '0;
            if (decHit) begin
              idxQ    <= decIdx;
              oPSel   <= decSel;
              oPAddr  <= iAddr;
              oPWrite <= iWe;
              oPWData <= iWData;
              oPStrb  <= iWe ? iBe : '0;
              state   <= SETUP;
            end else begin
              state   <= DONE;
            end
          end
        end
        SETUP: begin
          oPEnable <= 1'b1;
`ifdef APB_TIMEOUT_EN
          toCnt    <= '0;
`endif
          state    <= ACCESS;
        end
        ACCESS: begin
          if (selReady) begin
            oRData   <= oPWrite ? '0 : selData;
            oErr     <= selErr;
            oPSel    <= '0;
            oPEnable <= 1'b0;
            state    <= DONE;
          end
`ifdef APB_TIMEOUT_EN
          // Abort on the TIMEOUT-th ACCESS cycle that still sees no ready.
          else if (toCnt == TO_W'(TIMEOUT - 1)) begin
            oRData   <= APB_TIMEOUT_ERR_DATA;
            oErr     <= 1'b1;
            oPSel    <= '0;
            oPEnable <= 1'b0;
            state    <= DONE;
          end else begin
            toCnt    <= toCnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_apb_master.sv
// Directed scoreboard bench for rv32i_apb_master: per-cycle APB phase checks plus queued completion results.
module tb_rv32i_apb_master;

  localparam int unsigned NUM_SLV = 4;

  logic                  iClk = 1'b0;
  logic                  iRst;
  logic                  iReq;
  logic                  iWe;
  logic [31:0]           iAddr;
  logic [31:0]           iWData;
  logic [3:0]            iBe;
  logic                  oStall;
  logic                  oDone;
  logic [31:0]           oRData;
  logic                  oErr;
  logic [31:0]           oPAddr;
  logic                  oPWrite;
  logic [NUM_SLV-1:0]    oPSel;
  logic                  oPEnable;
  logic [31:0]           oPWData;
  logic [3:0]            oPStrb;
  logic [32*NUM_SLV-1:0] iPRData;
  logic [NUM_SLV-1:0]    iPReady;
  logic [NUM_SLV-1:0]    iPSlvErr;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cmps = 0;
  int   errs = 0;

  always #5 iClk = ~iClk;

  rv32i_apb_master #(
    .NUM_SLV      (NUM_SLV),
    .BASE_ADDR    (32'h1000_0000),
    .SLV_SIZE_LOG2(12),
    .TIMEOUT      (8)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iReq    (iReq),
    .iWe     (iWe),
    .iAddr   (iAddr),
    .iWData  (iWData),
    .iBe     (iBe),
    .oStall  (oStall),
    .oDone   (oDone),
    .oRData  (oRData),
    .oErr    (oErr),
    .oPAddr  (oPAddr),
    .oPWrite (oPWrite),
    .oPSel   (oPSel),
    .oPEnable(oPEnable),
    .oPWData (oPWData),
    .oPStrb  (oPStrb),
    .iPRData (iPRData),
    .iPReady (iPReady),
    .iPSlvErr(iPSlvErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmps++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Non-selected slaves always drive ready/error noise so any mis-selection shows up.
  task automatic idleSlaves(input logic [NUM_SLV-1:0] sel);
    iPReady  = ~sel;
    iPSlvErr = ~sel;
    iPRData  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Called at a negedge; returns at a negedge one cycle after oDone.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [NUM_SLV-1:0] expSel, input int waits,
                      input logic [31:0] slvData, input logic slvErr,
                      input logic [31:0] expRData, input logic expErr, input int expCycles);
    exp_t e;
    exp_t got;
    int   stallCnt;
    bit   done;
    e.rdata = expRData;
    e.err   = expErr;
    sb.push_back(e);
    iReq = 1'b1; iWe = we; iAddr = addr; iWData = wdata; iBe = be;
    idleSlaves(expSel);
    #1;
    check("stall_on_req", oStall, 1);
    check("psel_in_idle", oPSel, 0);
    stallCnt = 1;
    done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge iClk);
      @(negedge iClk);
      if (oDone) begin
        done = 1;
        check("done_cycle", c, expCycles);
        check("stall_count", stallCnt, expCycles);
        check("stall_at_done", oStall, 0);
        check("psel_at_done", oPSel, 0);
        check("penable_at_done", oPEnable, 0);
        check("sb_nonempty", sb.size(), 1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check("rdata", oRData, got.rdata);
          check("err", oErr, got.err);
        end
        iReq = 1'b0;
        idleSlaves(expSel);
      end else begin
        if (oStall) stallCnt++;
        check("psel", oPSel, expSel);
        check("penable", oPEnable, (c >= 2));
        check("paddr", oPAddr, addr);
        check("pwrite", oPWrite, we);
        check("pwdata", oPWData, wdata);
        check("pstrb", oPStrb, we ? be : 4'b0000);
        if (c == 2 + waits) begin
          iPReady  = '1;
          iPSlvErr = slvErr ? '1 : ~expSel;
          for (int k = 0; k < NUM_SLV; k++) begin
            if (expSel[k]) iPRData[32*k +: 32] = slvData;
          end
        end
      end
    end
    check("done_seen", {31'b0, done}, 1);
    @(posedge iClk);
    @(negedge iClk);
    check("done_one_cycle", oDone, 0);
    check("stall_after", oStall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst = 1'b0;
    iReq = 1'b1; iWe = 1'b1; iAddr = 32'h1000_1004; iWData = 32'hCAFE_0001; iBe = 4'b0011;
    idleSlaves(4'b0010);
    repeat (3) begin
      @(negedge iClk);
      check("rst_psel", oPSel, 0);
      check("rst_penable", oPEnable, 0);
      check("rst_stall", oStall, 0);
      check("rst_done", oDone, 0);
      check("rst_err", oErr, 0);
      check("rst_rdata", oRData, 0);
      check("rst_paddr", oPAddr, 0);
      check("rst_pwdata", oPWData, 0);
      check("rst_pstrb", oPStrb, 0);
      check("rst_pwrite", oPWrite, 0);
    end
    iRst = 1'b1;

    // Store held across reset release, slave 1, zero wait states
    xfer(1'b1, 32'h1000_1004, 32'hCAFE_0001, 4'b0011, 4'b0010, 0, 32'h0, 1'b0,
         32'h0, 1'b0, 3);
    // Load from slave 3 with two wait states
    xfer(1'b0, 32'h1000_3000, 32'h0, 4'b1111, 4'b1000, 2, 32'h1234_5678, 1'b0,
         32'h1234_5678, 1'b0, 5);
    // Unmapped: above the last slave, and just below the window
    xfer(1'b0, 32'h1000_4000, 32'h0, 4'b1111, 4'b0000, 1000, 32'h0, 1'b0,
         32'h0, 1'b1, 1);
    xfer(1'b0, 32'h0FFF_FFFC, 32'h0, 4'b1111, 4'b0000, 1000, 32'h0, 1'b0,
         32'h0, 1'b1, 1);
    // Slave error on a load, then a normal store
    xfer(1'b0, 32'h1000_2010, 32'h0, 4'b1111, 4'b0100, 1, 32'hA5A5_0F0F, 1'b1,
         32'hA5A5_0F0F, 1'b1, 4);
    xfer(1'b1, 32'h1000_0008, 32'h5555_AAAA, 4'b1111, 4'b0001, 0, 32'hFFFF_FFFF, 1'b0,
         32'h0, 1'b0, 3);
    // Last byte of the window maps to slave 3
    xfer(1'b0, 32'h1000_3FFF, 32'h0, 4'b0000, 4'b1000, 0, 32'h0BAD_F00D, 1'b0,
         32'h0BAD_F00D, 1'b0, 3);
`ifdef APB_TIMEOUT_EN
    xfer(1'b0, 32'h1000_0000, 32'h0, 4'b1111, 4'b0001, 1000, 32'h0, 1'b0,
         32'hDEAD_BEEF, 1'b1, 10);
`endif

    // Reset asserted mid-ACCESS: select drops at once, no completion
    iReq = 1'b1; iWe = 1'b0; iAddr = 32'h1000_2000; iWData = 32'h0; iBe = 4'b1111;
    idleSlaves(4'b0100);
    @(posedge iClk); @(negedge iClk);
    @(posedge iClk); @(negedge iClk);
    check("mid_psel_access", oPSel, 4'b0100);
    check("mid_penable_access", oPEnable, 1);
    #2 iRst = 1'b0;
    #1;
    check("mid_rst_psel", oPSel, 0);
    check("mid_rst_penable", oPEnable, 0);
    check("mid_rst_stall", oStall, 0);
    iReq = 1'b0;
    repeat (3) begin
      @(negedge iClk);
      check("mid_rst_no_done", oDone, 0);
    end
    iRst = 1'b1;
    @(negedge iClk);
    check("post_rst_done", oDone, 0);

    xfer(1'b0, 32'h1000_3100, 32'h0, 4'b1111, 4'b1000, 1, 32'h0BAD_F00D, 1'b0,
         32'h0BAD_F00D, 1'b0, 4);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
